// File: rtl/tmds_ser_pkg.sv
// tmds_ser_pkg: shared TMDS constants, control tokens and serializer state encoding
package tmds_ser_pkg;
  localparam int TMDS_W = 10;
  localparam logic [TMDS_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTRL_11 = 10'b1010101011;
  localparam logic [TMDS_W-1:0] CLK_PATTERN = 10'b0000011111;
  typedef enum logic {ST_IDLE, ST_RUN} st_t;
endpackage

// File: rtl/tmds_ser_if.sv
// tmds_ser_if: word handshake, underrun control and serial outputs of the TMDS serializer
interface tmds_ser_if
  import tmds_ser_pkg::*;
#(
  parameter int LANES = 3
);
  logic [LANES*TMDS_W-1:0] dat_i;
  logic dat_vld_i;
  logic dat_rdy_o;
  logic urun_clr_i;
  logic urun_o;
  logic [LANES:0] ser_o;
  modport master(output dat_i, dat_vld_i, urun_clr_i, input dat_rdy_o, ser_o, urun_o);
  modport slave(input dat_i, dat_vld_i, urun_clr_i, output dat_rdy_o, ser_o, urun_o);
endinterface

// File: rtl/tmds_shreg.sv
// tmds_shreg: 10-bit load/shift-right register emitting its LSB each bit clock
module tmds_shreg
  import tmds_ser_pkg::*;
#(
  parameter logic [TMDS_W-1:0] INIT = CTRL_00
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld,
  input  logic [TMDS_W-1:0] d,
  output logic              q
);
  logic [TMDS_W-1:0] sh;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sh <= INIT;
    else sh <= ld ? d : {1'b0, sh[TMDS_W-1:1]};
  assign q = sh[0];
endmodule

// File: rtl/tmds_ser.sv
// tmds_ser: TMDS parallel-to-serial stage with holding buffer, clock lane and underrun flag
module tmds_ser
  import tmds_ser_pkg::*;
#(
  parameter int LANES = 3,
  parameter logic [TMDS_W-1:0] IDLE_WORD = CTRL_00
) (
  input logic clk_i,
  input logic rst_i,
  tmds_ser_if.slave bus
);
  logic [3:0] bit_cnt;
  logic [LANES*TMDS_W-1:0] hold_q;
  logic hold_vld, urun, ld, acc;
  logic [LANES:0] ser;
  st_t st;
  assign ld = bit_cnt == 4'd9;
  assign acc = bus.dat_vld_i && !hold_vld;
  assign bus.dat_rdy_o = !hold_vld;
  assign bus.urun_o = urun;
  assign bus.ser_o = ser;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bit_cnt <= '0;
      hold_vld <= 1'b0;
      hold_q <= '0;
      st <= ST_IDLE;
      urun <= 1'b0;
    end else begin
      bit_cnt <= ld ? 4'd0 : bit_cnt + 4'd1;
      hold_vld <= acc || (hold_vld && !ld);
      if (acc) hold_q <= bus.dat_i;
      if (acc) st <= ST_RUN;
      // an empty load only counts as underrun once real data has started flowing
      urun <= (ld && !hold_vld && st == ST_RUN) || (urun && !bus.urun_clr_i);
    end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    tmds_shreg #(.INIT(IDLE_WORD)) u_sh (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .ld   (ld),
      .d    (hold_vld ? hold_q[l*TMDS_W+:TMDS_W] : IDLE_WORD),
      .q    (ser[l])
    );
  end
  tmds_shreg #(.INIT(CLK_PATTERN)) u_ck (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .ld   (ld),
    .d    (CLK_PATTERN),
    .q    (ser[LANES])
  );
endmodule
